// File: rtl/vga_hex_panel_writer.sv
// Debug-panel text writer: snapshots NUM_CH channels and streams them as hex text
// into the VGA text buffer, highlighting digits of channels that changed since the last pass.

module vga_hex_panel_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snap_en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] snap_q,
    output logic              changed
);
    logic [DATA_W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q <= '0;
            prev_q <= '0;
        end else if (snap_en) begin
            prev_q <= snap_q;
            snap_q <= d;
        end
    end

    assign changed = (snap_q != prev_q);
endmodule

module vga_hex_panel_writer #(
    parameter int NUM_CH         = 32,
    parameter int DATA_W         = 32,
    parameter int COLS           = 80,
    parameter int BASE_ROW       = 0,
    parameter int BASE_COL       = 0,
    parameter int FIELDS_PER_ROW = 4,
    parameter int ADDR_W         = 12,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     refresh_req,
    input  logic                     freeze,
    output logic                     display_wen,
    output logic [ADDR_W-1:0]        display_w_addr,
    output logic [7:0]               display_w_data,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int NDIG = DATA_W / 4;
    localparam int FW   = NDIG + 4;
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int KW   = $clog2(FW);
    localparam int FFW  = (FIELDS_PER_ROW > 1) ? $clog2(FIELDS_PER_ROW) : 1;

    // Fields of one row are contiguous, so only a row change needs a jump.
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ROW * COLS + BASE_COL);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS - (FIELDS_PER_ROW * FW - 1));

    typedef enum logic [1:0] {IDLE, SNAP, EMIT} state_t;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } cell_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   c_q, n_c;
    logic [KW-1:0]                   k_q, n_k;
    logic [FFW-1:0]                  f_q, n_f;
    logic [ADDR_W-1:0]               n_addr;
    cell_t                           out_q, cell_d;
    logic                            frame_done_q;
    logic                            pending_q;
    logic                            auto_hit;
    logic                            start, load, last_cell, snap_en;
    logic [NUM_CH-1:0][DATA_W-1:0]   snap_arr;
    logic [NUM_CH-1:0]               changed;
    logic [DATA_W-1:0]               word;
    logic [3:0]                      nib;
    logic [7:0]                      chan8;
    logic [6:0]                      ch_ascii;
    logic                            hl;

    function automatic logic [6:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (7'h30 + {3'b000, n}) : (7'h37 + {3'b000, n});
    endfunction

    assign snap_en = (state_q == SNAP);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        vga_hex_panel_lane #(.DATA_W(DATA_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .snap_en (snap_en),
            .d       (ch_data[i*DATA_W +: DATA_W]),
            .snap_q  (snap_arr[i]),
            .changed (changed[i])
        );
    end

    if (REFRESH_CYCLES > 0) begin : g_auto
        localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
        logic [RW-1:0] cnt_q;
        assign auto_hit = (cnt_q == RW'(REFRESH_CYCLES - 1));
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)          cnt_q <= '0;
            else if (auto_hit) cnt_q <= '0;
            else               cnt_q <= cnt_q + 1'b1;
        end
    end else begin : g_no_auto
        assign auto_hit = 1'b0;
    end

    assign start     = (pending_q | refresh_req) & ~freeze;
    assign last_cell = (k_q == KW'(FW - 1)) && (c_q == CW'(NUM_CH - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = SNAP;
            SNAP: begin
                state_d = EMIT;
                load    = 1'b1;
            end
            EMIT: begin
                if (last_cell) state_d = IDLE;
                else           load    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Position of the cell that will be presented after the next edge.
    always_comb begin
        n_c    = c_q;
        n_k    = k_q;
        n_f    = f_q;
        n_addr = out_q.addr;
        if (state_q == SNAP) begin
            n_c    = '0;
            n_k    = '0;
            n_f    = '0;
            n_addr = START_ADDR;
        end else if (k_q == KW'(FW - 1)) begin
            n_k = '0;
            n_c = c_q + 1'b1;
            if (f_q == FFW'(FIELDS_PER_ROW - 1)) begin
                n_f    = '0;
                n_addr = out_q.addr + ROW_STEP;
            end else begin
                n_f    = f_q + 1'b1;
                n_addr = out_q.addr + 1'b1;
            end
        end else begin
            n_k    = k_q + 1'b1;
            n_addr = out_q.addr + 1'b1;
        end
    end

    always_comb begin
        word     = snap_arr[n_c];
        nib      = 4'(word >> (4 * (NDIG - 1 - (int'(n_k) - 3))));
        chan8    = 8'(n_c);
        hl       = 1'b0;
        ch_ascii = 7'h20;
        if (n_k == KW'(0))            ch_ascii = hex_ascii(chan8[7:4]);
        else if (n_k == KW'(1))       ch_ascii = hex_ascii(chan8[3:0]);
        else if (n_k == KW'(2))       ch_ascii = 7'h3A;
        else if (n_k == KW'(FW - 1))  ch_ascii = 7'h20;
        else begin
            ch_ascii = hex_ascii(nib);
            hl       = changed[n_c];
        end
        cell_d.wen  = 1'b1;
        cell_d.addr = n_addr;
        cell_d.data = {hl, ch_ascii};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            c_q          <= '0;
            k_q          <= '0;
            f_q          <= '0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == EMIT) && last_cell;
            if (load) begin
                c_q   <= n_c;
                k_q   <= n_k;
                f_q   <= n_f;
                out_q <= cell_d;
            end else begin
                out_q <= '0;
            end
            // Leaving IDLE consumes the request; anything arriving later is merged into one.
            if (state_q == IDLE && start)      pending_q <= 1'b0;
            else if (refresh_req || auto_hit)  pending_q <= 1'b1;
        end
    end

    assign display_wen    = out_q.wen;
    assign display_w_addr = out_q.addr;
    assign display_w_data = out_q.data;
    assign busy           = (state_q != IDLE);
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_vga_hex_panel_writer.sv
// Directed bench: default-parameter panel plus a small wrapping, auto-refreshing panel.
module tb_vga_hex_panel_writer;
    logic clk, rst, refresh_req, freeze, freeze2;
    logic [31:0][31:0] chd;
    logic [1:0][7:0]   chd2;
    logic              wen, busy, fd, wen2, busy2, fd2;
    logic [11:0]       addr;
    logic [5:0]        addr2;
    logic [7:0]        data, data2;

    vga_hex_panel_writer dut (
        .clk(clk), .rst(rst), .ch_data(chd), .refresh_req(refresh_req), .freeze(freeze),
        .display_wen(wen), .display_w_addr(addr), .display_w_data(data),
        .busy(busy), .frame_done(fd)
    );

    vga_hex_panel_writer #(
        .NUM_CH(2), .DATA_W(8), .COLS(40), .BASE_ROW(1), .BASE_COL(30),
        .FIELDS_PER_ROW(1), .ADDR_W(6), .REFRESH_CYCLES(100)
    ) dut2 (
        .clk(clk), .rst(rst), .ch_data(chd2), .refresh_req(1'b0), .freeze(freeze2),
        .display_wen(wen2), .display_w_addr(addr2), .display_w_data(data2),
        .busy(busy2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem  [0:4095];
    logic [7:0] mem2 [0:63];
    int wlog [0:15];
    int vectors = 0, errs = 0;
    int nwr, nhl, nfd, first_wr, fd_edge, low_run, last_gap, nwr2, nfd2, t, n, started;
    logic prev_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle; outputs are logged at the falling edge, edges counted as the consuming rising edge.
    task automatic tick();
        @(negedge clk);
        if (wen) begin
            mem[addr] = data;
            if (nwr < 16) wlog[nwr] = int'(addr);
            nwr++;
            if (data[7]) nhl++;
            if (first_wr < 0) first_wr = cyc + 1;
        end
        if (fd) begin nfd++; fd_edge = cyc + 1; end
        if (busy && !prev_busy) last_gap = low_run;
        low_run   = busy ? 0 : low_run + 1;
        prev_busy = busy;
        if (wen2) begin mem2[addr2] = data2; nwr2++; end
        if (fd2) nfd2++;
    endtask

    task automatic clear_log();
        nwr = 0; nhl = 0; nfd = 0; first_wr = -1; fd_edge = -1;
    endtask

    task automatic pulse(output int te);
        refresh_req = 1'b1;
        te = cyc + 1;
        tick();
        refresh_req = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target, input int bound);
        int k = 0;
        while (nfd < target && k < bound) begin tick(); k++; end
        check(tag, nfd, target);
    endtask

    task automatic wait_wr(input int target);
        int k = 0;
        while (nwr < target && k < 1000) begin tick(); k++; end
    endtask

    task automatic chk_field(input string tag, input int base, input string s, input bit hl, input bit d2);
        logic [7:0] e;
        for (int k = 0; k < s.len(); k++) begin
            e = s[k];
            if (hl && k >= 3 && k < s.len() - 1) e[7] = 1'b1;
            if (d2) check($sformatf("%s[%0d]", tag, k), mem2[base + k], e);
            else    check($sformatf("%s[%0d]", tag, k), mem[base + k], e);
        end
    endtask

    initial begin
        rst = 1'b0; refresh_req = 1'b0; freeze = 1'b0; freeze2 = 1'b1;
        chd = '0; chd[0] = 32'h1234ABCD; chd[3] = 32'h11; chd[5] = 32'h0000000F;
        chd2 = {8'h3C, 8'hA5};
        nwr2 = 0; nfd2 = 0; low_run = 0; last_gap = -1;
        clear_log();
        #2;
        check("rst_wen", wen, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", fd, 0);
        check("rst_wen2", wen2, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Pass 1: first pass highlights every nonzero channel; ch31 change mid-pass is ignored.
        clear_log();
        pulse(t);
        wait_wr(100);
        chd[31] = 32'hFFFFFFFF;
        wait_fd("p1_done", 1, 600);
        chd[31] = '0;
        check("p1_first_wr", first_wr, t + 2);
        check("p1_fd_edge", fd_edge, t + 2 + 384);
        check("p1_nwr", nwr, 384);
        for (int i = 0; i < 12; i++) check($sformatf("p1_order%0d", i), wlog[i], i);
        chk_field("p1_ch0", 0, "00:1234ABCD ", 1'b1, 1'b0);
        chk_field("p1_ch5", 92, "05:0000000F ", 1'b1, 1'b0);
        chk_field("p1_ch1", 12, "01:00000000 ", 1'b0, 1'b0);
        chk_field("p1_ch31", 596, "1F:00000000 ", 1'b0, 1'b0);
        check("p1_nhl", nhl, 24);

        // Pass 2: only ch3 changed.
        chd[3] = 32'h22;
        clear_log();
        pulse(t);
        wait_fd("p2_done", 1, 600);
        check("p2_nhl", nhl, 8);
        chk_field("p2_ch3", 36, "03:00000022 ", 1'b1, 1'b0);
        chk_field("p2_ch0", 0, "00:1234ABCD ", 1'b0, 1'b0);

        // Two mid-pass requests merge into exactly one back-to-back pass.
        clear_log();
        pulse(t);
        wait_wr(100);
        refresh_req = 1'b1; tick(); refresh_req = 1'b0;
        repeat (5) tick();
        refresh_req = 1'b1; tick(); refresh_req = 1'b0;
        wait_fd("b2b_done", 2, 1200);
        repeat (450) tick();
        check("b2b_nfd", nfd, 2);
        check("b2b_nwr", nwr, 768);
        check("b2b_gap", last_gap, 1);

        // Frozen auto-refreshing panel writes nothing; unfreezing starts the held pass.
        nwr2 = 0; nfd2 = 0;
        repeat (500) tick();
        check("frz_nwr", nwr2, 0);
        check("frz_busy", busy2, 0);
        freeze2 = 1'b0;
        started = 0;
        for (int i = 0; i < 2; i++) begin tick(); if (busy2) started = 1; end
        check("frz_start", started, 1);
        n = 0;
        while (nfd2 < 1 && n < 50) begin tick(); n++; end
        check("frz_nfd", nfd2, 1);
        check("frz_nwr2", nwr2, 12);
        chk_field("wrap_ch0", 6, "00:A5 ", 1'b1, 1'b1);
        chk_field("wrap_ch1", 46, "01:3C ", 1'b1, 1'b1);

        // Reset at cell 50 clears outputs asynchronously and forgets history.
        clear_log();
        pulse(t);
        wait_wr(50);
        #2 rst = 1'b0;
        #1;
        check("mrst_wen", wen, 0);
        check("mrst_busy", busy, 0);
        check("mrst_fd", fd, 0);
        check("mrst_addr", addr, 0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        clear_log();
        pulse(t);
        wait_fd("mrst_done", 1, 600);
        check("mrst_nhl", nhl, 24);
        check("mrst_ch0d", mem[3], 8'hB1);
        check("mrst_ch3d", mem[39], 8'hB0);
        check("mrst_ch5d", mem[102], 8'hC6);
        check("mrst_ch1d", mem[15], 8'h30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
